// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/control bundle for the register-file issue scoreboard.
// The master modport is the pipeline side and the slave modport is the scoreboard.
interface reg_scoreboard_if;
    logic        Issue_Valid;
    logic [4:0]  Issue_Rs;
    logic [4:0]  Issue_Rt;
    logic        Issue_Rs_Used;
    logic        Issue_Rt_Used;
    logic [4:0]  Issue_Rd;
    logic        Issue_Rd_Write;
    logic        Issue_Ready;
    logic        WB_Valid;
    logic [4:0]  WB_Rd;
    logic        Kill_Valid;
    logic [4:0]  Kill_Rd;
    logic        Drain_Req;
    logic        Drain_Ack;
    logic        Busy;
    logic [15:0] Stall_Count;
    logic        Err;

    modport master (
        output Issue_Valid, Issue_Rs, Issue_Rt, Issue_Rs_Used, Issue_Rt_Used,
        output Issue_Rd, Issue_Rd_Write, WB_Valid, WB_Rd, Kill_Valid, Kill_Rd, Drain_Req,
        input  Issue_Ready, Drain_Ack, Busy, Stall_Count, Err
    );

    modport slave (
        input  Issue_Valid, Issue_Rs, Issue_Rt, Issue_Rs_Used, Issue_Rt_Used,
        input  Issue_Rd, Issue_Rd_Write, WB_Valid, WB_Rd, Kill_Valid, Kill_Rd, Drain_Req,
        output Issue_Ready, Drain_Ack, Busy, Stall_Count, Err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: stalls decode on RAW hazards and counter
// saturation, releases on writeback/squash, and offers a drain handshake.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic             Clk,
    input  logic             Clr,
    reg_scoreboard_if.slave  sb
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAINING = 2'd1,
        ST_DRAINED  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic [CNT_W-1:0]  eff_s [NREG];
    logic [NREG-1:0]   under_s;
    logic              hazard_s;
    logic              sat_s;
    logic              ready_s;
    logic              fire_s;
    logic              busy_d, busy_q;
    logic              err_d, err_q;
    logic              drain_ack_d, drain_ack_q;
    logic [15:0]       stall_d, stall_q;

    // Effective counts: writeback and squash of this cycle already applied, clamped at zero
    always_comb begin
        logic [CNT_W:0] dec_v;
        logic [CNT_W:0] cnt_v;
        for (int r = 0; r < NREG; r++) begin
            dec_v = (CNT_W+1)'(sb.WB_Valid && (sb.WB_Rd == 5'(r)))
                  + (CNT_W+1)'(sb.Kill_Valid && (sb.Kill_Rd == 5'(r)));
            cnt_v = {1'b0, cnt_q[r]};
            if (r == 0) begin
                eff_s[r]   = {CNT_W{1'b0}};
                under_s[r] = 1'b0;
            end else if (dec_v > cnt_v) begin
                eff_s[r]   = {CNT_W{1'b0}};
                under_s[r] = 1'b1;
            end else begin
                eff_s[r]   = CNT_W'(cnt_v - dec_v);
                under_s[r] = 1'b0;
            end
        end
    end

    // Issue gating: hazard and saturation look only at effective counts, never at Issue_Valid
    always_comb begin
        hazard_s = (sb.Issue_Rs_Used && (sb.Issue_Rs != 5'd0) && (eff_s[sb.Issue_Rs] != {CNT_W{1'b0}}))
                || (sb.Issue_Rt_Used && (sb.Issue_Rt != 5'd0) && (eff_s[sb.Issue_Rt] != {CNT_W{1'b0}}));
        sat_s    = sb.Issue_Rd_Write && (sb.Issue_Rd != 5'd0) && (eff_s[sb.Issue_Rd] == {CNT_W{1'b1}});
        ready_s  = !Clr && (state_q == ST_RUN) && !hazard_s && !sat_s;
        fire_s   = sb.Issue_Valid && ready_s;
    end

    // Next counts, busy summary and sticky underflow error
    always_comb begin
        logic inc_v;
        busy_d = 1'b0;
        err_d  = err_q | (|under_s);
        for (int r = 0; r < NREG; r++) begin
            inc_v    = fire_s && sb.Issue_Rd_Write && (sb.Issue_Rd == 5'(r)) && (r != 0);
            cnt_d[r] = eff_s[r] + CNT_W'(inc_v);
            busy_d   = busy_d | (cnt_d[r] != {CNT_W{1'b0}});
        end
    end

    // Saturating stall counter
    always_comb begin
        if (sb.Issue_Valid && !ready_s && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Drain FSM next-state; dropping the request always wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (sb.Drain_Req) state_d = ST_DRAINING;
                else              state_d = ST_RUN;
            end
            ST_DRAINING: begin
                if (!sb.Drain_Req) state_d = ST_RUN;
                else if (!busy_d)  state_d = ST_DRAINED;
                else               state_d = ST_DRAINING;
            end
            ST_DRAINED: begin
                if (!sb.Drain_Req) state_d = ST_RUN;
                else               state_d = ST_DRAINED;
            end
            default: state_d = ST_RUN;
        endcase
        drain_ack_d = (state_d == ST_DRAINED);
    end

    // State and output registers
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            drain_ack_q <= 1'b0;
            stall_q     <= 16'd0;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            drain_ack_q <= drain_ack_d;
            stall_q     <= stall_d;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign sb.Issue_Ready = ready_s;
    assign sb.Drain_Ack   = drain_ack_q;
    assign sb.Busy        = busy_q;
    assign sb.Stall_Count = stall_q;
    assign sb.Err         = err_q;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Issue-side scoreboard for the register file in the MIPS pipelined CPU. It sits between decode and the register file and tracks, per architectural register, how many in-flight instructions still have to write it. Decode is stalled on read-after-write hazards and on counter saturation, and pending counts are released by writeback or squash. It also provides a drain handshake so the exception and control logic can wait until all register writes have retired.

## Interface
- NREG, 32: number of architectural registers (address width fixed at 5).
- CNT_W, 2: width of each pending counter; at most 2^CNT_W-1 in-flight writes per register.
- Clk  in  1  clock; all state updates on rising edge.
- Clr  in  1  reset: asynchronous, active-high.
- Issue_Valid  in  1  decode presents an instruction.
- Issue_Rs / Issue_Rt  in  5 each  source register addresses.
- Issue_Rs_Used / Issue_Rt_Used  in  1 each  the corresponding source is actually read.
- Issue_Rd  in  5  destination register address.
- Issue_Rd_Write  in  1  the instruction writes Issue_Rd.
- Issue_Ready  out  1  the instruction may issue this cycle (combinational).
- WB_Valid, WB_Rd  in  1, 5  writeback retiring a write to WB_Rd (same cycle as Reg_Write to the register file).
- Kill_Valid, Kill_Rd  in  1, 5  squashed in-flight instruction that had destination Kill_Rd.
- Drain_Req  in  1  request to quiesce issue.
- Drain_Ack  out  1  registered; no pending writes remain and issue is blocked.
- Busy  out  1  registered; at least one counter is nonzero.
- Stall_Count  out  16  registered count of stalled issue cycles, saturating.
- Err  out  1  registered, sticky; a decrement hit a zero counter.

## Operation
- Counters cnt[1..NREG-1] are CNT_W wide. Register 0 has no counter: it never hazards and is never incremented.
- Decrements per register r per cycle: dec(r) = (WB_Valid && WB_Rd==r) + (Kill_Valid && Kill_Rd==r), range 0..2.
- Effective count eff(r) = cnt(r) - dec(r), clamped at 0. This models the register file writing on the falling edge, so a consumer is released in the same cycle as its producer's writeback.
- Hazard occurs when (Rs_Used && Rs!=0 && eff(Rs)>0) or (Rt_Used && Rt!=0 && eff(Rt)>0).
- Saturation occurs when Rd_Write && Rd!=0 && eff(Rd)==2^CNT_W-1.
- Issue_Ready = !Clr && state==RUN && !hazard && !saturation.
- Fire = Issue_Valid && Issue_Ready.
- Next cnt(r) = eff(r) + (Fire && Rd_Write && Issue_Rd==r). Simultaneous issue and retire on the same register net out.
- Underflow occurs when dec(r) > cnt(r). The counter clamps to 0 and Err is set. Err clears only on Clr.
- Stall_Count increments when Issue_Valid && !Issue_Ready, and saturates at 0xFFFF.
- Busy is registered: OR of next cnt values.
- FSM states:
  - RUN: Drain_Req moves to DRAINING.
  - DRAINING: issue is blocked. Moves to DRAINED when all next counts are 0. Moves back to RUN if Drain_Req drops.
  - DRAINED: Drain_Ack=1. Moves to RUN when Drain_Req drops. WB/Kill in this state only update Err.

## Timing
- Reset values: all counters 0, state RUN, Drain_Ack 0, Busy 0, Stall_Count 0, Err 0. Issue_Ready is 0 while Clr is high and 1 afterwards.
- Issue to hazard visible: the following cycle. An instruction issued in cycle N writing r causes a consumer in N+1 to stall.
- Writeback in cycle N releases a consumer in cycle N; issue fires in N.
- Drain timing:
  - Drain_Req high in cycle N with all counters 0: Issue_Ready drops in N (combinational from state only after the edge, so at N+1). Drain_Ack is 1 from N+2.
  - Otherwise Drain_Ack is 1 one cycle after the last retirement.
- Clr mid-operation zeroes everything immediately. Err is cleared as well.
- Issue_Ready must not depend on Issue_Valid (no combinational loop with decode).

## Test plan
- Reset then issue addu $3 (Rd=3) in cycle 0, then consumer Rs=3 in cycle 1 -> Issue_Ready=0 and Stall_Count increments each cycle; WB_Rd=3 in cycle 4 -> Issue_Ready=1 in cycle 4, Stall_Count=3.
- Issue three writes to $5 with no WB -> cnt(5)=3; a fourth write to $5 -> Issue_Ready=0 (saturation). WB_Rd=5 plus simultaneous issue to $5 -> cnt stays 3.
- Rd=0 with Rd_Write, and Rs=0 used -> never stall, Busy stays 0.
- cnt(7)=1, WB_Rd=7 and Kill_Rd=7 in the same cycle -> cnt(7)=0, Err=1 and remains 1 until Clr.
- Two pending writes to $2 and $9, Drain_Req high -> Issue_Ready=0 from the next cycle. Retire both -> Drain_Ack=1 the cycle after the last retirement. Drop Drain_Req -> RUN and Issue_Ready=1.
- Clr pulsed while cnt(4)=2 and DRAINING -> all outputs return to reset values asynchronously; a consumer of $4 issues immediately after release.
